// File: rtl/gray_step_decoder_if.sv
// Gray-code link bundle between a counter (master) and its step decoder (slave).
// Carries the sampled code and clear request inward and the classification results outward.
interface gray_step_decoder_if #(
  parameter int WIDTH = 3,
  parameter int POS_W = 16
);
  logic             sample_en;
  logic [WIDTH-1:0] gray_in;
  logic             clr_err;
  logic [WIDTH-1:0] bin_out;
  logic             valid;
  logic             step_up;
  logic             step_dn;
  logic             hold;
  logic             err;
  logic [7:0]       err_cnt;
  logic [POS_W-1:0] pos_cnt;

  modport master (
    output sample_en, gray_in, clr_err,
    input  bin_out, valid, step_up, step_dn, hold, err, err_cnt, pos_cnt
  );

  modport slave (
    input  sample_en, gray_in, clr_err,
    output bin_out, valid, step_up, step_dn, hold, err, err_cnt, pos_cnt
  );
endinterface

// File: rtl/gray_step_decoder.sv
// Gray-code receiver: converts, classifies each sample as up/down/hold/illegal, tracks position.
// Latency 1 cycle from the sampling edge; no backpressure, a sample is taken whenever sample_en is high.
module gray_step_decoder #(
  parameter int WIDTH = 3,
  parameter int POS_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  gray_step_decoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  state_t                   state;
  logic [WIDTH-1:0]         bin_q;
  logic                     valid_q;
  logic                     up_q;
  logic                     dn_q;
  logic                     hold_q;
  logic                     err_q;
  logic [7:0]               err_cnt_q;
  logic signed [POS_W-1:0]  pos_q;

  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] delta;
  logic             is_hold;
  logic             is_up;
  logic             is_dn;
  logic             illegal_now;

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign b_new[i] = ^bus.gray_in[WIDTH-1:i];
  end

  assign delta       = b_new - bin_q;
  assign is_hold     = (delta == '0);
  assign is_up       = (delta == WIDTH'(1));
  assign is_dn       = (delta == {WIDTH{1'b1}});
  assign illegal_now = bus.sample_en && (state != IDLE) && !(is_hold || is_up || is_dn);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bin_q     <= '0;
      valid_q   <= 1'b0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      hold_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      pos_q     <= '0;
    end else begin
      up_q   <= 1'b0;
      dn_q   <= 1'b0;
      hold_q <= 1'b0;
      if (bus.sample_en) begin
        // The register always resyncs to the newest code, even after an illegal jump.
        bin_q <= b_new;
        if (state == IDLE) begin
          valid_q <= 1'b1;
          state   <= TRACK;
        end else if (illegal_now) begin
          state <= FAULT;
          err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          hold_q <= is_hold;
          up_q   <= is_up;
          dn_q   <= is_dn;
          if (is_up) pos_q <= pos_q + POS_W'(1);
          if (is_dn) pos_q <= pos_q - POS_W'(1);
        end
      end
      if (state == FAULT && bus.clr_err && !illegal_now) begin
        state <= TRACK;
        err_q <= 1'b0;
      end
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.valid   = valid_q;
  assign bus.step_up = up_q;
  assign bus.step_dn = dn_q;
  assign bus.hold    = hold_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;
  assign bus.pos_cnt = pos_q;
endmodule
